// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC owner with imem req/ack and decode valid/ready handshakes
// Optional feature macro: FETCH_TIMEOUT_EN (adds the ERROR state, the timeout counter and the fetch_error port)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_ADDR     = 32'h00000000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_out
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_error
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
`ifdef FETCH_TIMEOUT_EN
    ,
    ERROR
`endif
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next, instr_out_next, instr_pc_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_addr, pend_addr_next;
  logic [31:0] redirect_target;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt, to_cnt_next;
  logic          fetch_error_next;
`endif

  assign redirect_target = redirect_addr & ~32'h3;
  // pc_out only moves on an ack or outside REQ, so it doubles as the stable fetch address
  assign imem_addr = pc_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc_out     <= RESET_ADDR;
      instr_out  <= 32'h0;
      instr_pc   <= 32'h0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt      <= '0;
      fetch_error <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pc_out     <= pc_next;
      instr_out  <= instr_out_next;
      instr_pc   <= instr_pc_next;
      pend_valid <= pend_valid_next;
      pend_addr  <= pend_addr_next;
`ifdef FETCH_TIMEOUT_EN
      to_cnt      <= to_cnt_next;
      fetch_error <= fetch_error_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc_out;
    instr_out_next  = instr_out;
    instr_pc_next   = instr_pc;
    pend_valid_next = pend_valid;
    pend_addr_next  = pend_addr;
    imem_req        = 1'b0;
    instr_valid     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    to_cnt_next      = to_cnt;
    fetch_error_next = fetch_error;
`endif
    case (state)
      IDLE: begin
        state_next = REQ;
`ifdef FETCH_TIMEOUT_EN
        to_cnt_next = '0;
`endif
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect_valid || pend_valid) begin
            // returning word belongs to the squashed path; a same-cycle redirect is the newest target
            pc_next         = redirect_valid ? redirect_target : pend_addr;
            pend_valid_next = 1'b0;
          end else begin
            instr_out_next = imem_rdata;
            instr_pc_next  = pc_out;
            pc_next        = pc_out + 32'd4;
            state_next     = HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          to_cnt_next = '0;
`endif
        end else begin
          if (redirect_valid) begin
            pend_valid_next = 1'b1;
            pend_addr_next  = redirect_target;
          end
`ifdef FETCH_TIMEOUT_EN
          if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            fetch_error_next = 1'b1;
            state_next       = ERROR;
          end else begin
            to_cnt_next = to_cnt + 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (instr_ready) begin
          state_next = REQ;
        end
`ifdef FETCH_TIMEOUT_EN
        to_cnt_next = '0;
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      ERROR: begin
        state_next = ERROR;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - table-driven check of instruction_fetch_unit plus reset/timeout sequences
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] pc_out;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_error;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .pc_out         (pc_out)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_error    (fetch_error)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] out;
    logic [31:0] ipc;
    logic [31:0] pco;
  } vec_t;

  vec_t v[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] out, input logic [31:0] ipc,
                           input logic [31:0] pco);
    check({tag, "_req"},   {31'd0, imem_req},    {31'd0, req});
    check({tag, "_addr"},  imem_addr,            addr);
    check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, vld});
    check({tag, "_out"},   instr_out,            out);
    check({tag, "_ipc"},   instr_pc,             ipc);
    check({tag, "_pc"},    pc_out,               pco);
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    instr_ready    = 1'b0;
  endtask

  initial begin
    //            rv  ra            ack rd            rdy  req addr          vld out           ipc           pc
    v[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0};
    v[1]  = '{1'b0, 32'h0,        1'b1, 32'h20080005, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0};
    v[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        1'b1, 32'h20080005, 32'h0,        32'h4};
    v[3]  = '{1'b0, 32'h0,        1'b1, 32'h20080005, 1'b0, 1'b1, 32'h4,        1'b0, 32'h20080005, 32'h0,        32'h4};
    for (int i = 4; i <= 9; i++)
      v[i] = '{1'b0, 32'h0,       1'b0, 32'h0,        (i == 9), 1'b0, 32'h8,    1'b1, 32'h20080005, 32'h4,        32'h8};
    for (int i = 10; i <= 12; i++)
      v[i] = '{1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b0, 32'h20080005, 32'h4,        32'h8};
    v[13] = '{1'b0, 32'h0,        1'b1, 32'h00A00093, 1'b0, 1'b1, 32'h8,        1'b0, 32'h20080005, 32'h4,        32'h8};
    v[14] = '{1'b1, 32'h00400023, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        1'b1, 32'h00A00093, 32'h8,        32'hC};
    v[15] = '{1'b1, 32'h00000100, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400020, 1'b0, 32'h00A00093, 32'h8,        32'h00400020};
    v[16] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h00400020, 1'b0, 32'h00A00093, 32'h8,        32'h00400020};
    v[17] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00400020, 1'b0, 32'h00A00093, 32'h8,        32'h00400020};
    v[18] = '{1'b0, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b1, 32'h100,      1'b0, 32'h00A00093, 32'h8,        32'h100};
    v[19] = '{1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h104,      1'b1, 32'h11111111, 32'h100,      32'h104};
    v[20] = '{1'b0, 32'h0,        1'b1, 32'h22222222, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h11111111, 32'h100,      32'hFFFFFFFC};
    v[21] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222, 32'hFFFFFFFC, 32'h0};
    v[22] = '{1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h22222222, 32'hFFFFFFFC, 32'h0};
    v[23] = '{1'b1, 32'h300,      1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h22222222, 32'hFFFFFFFC, 32'h0};
    v[24] = '{1'b0, 32'h0,        1'b1, 32'h33,       1'b0, 1'b1, 32'h0,        1'b0, 32'h22222222, 32'hFFFFFFFC, 32'h0};
    v[25] = '{1'b1, 32'h404,      1'b1, 32'h55,       1'b0, 1'b1, 32'h300,      1'b0, 32'h22222222, 32'hFFFFFFFC, 32'h300};
    v[26] = '{1'b0, 32'h0,        1'b1, 32'h44,       1'b1, 1'b1, 32'h404,      1'b0, 32'h22222222, 32'hFFFFFFFC, 32'h404};
    v[27] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h408,      1'b1, 32'h44,       32'h404,      32'h408};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_TIMEOUT_EN
    check("reset_err", {31'd0, fetch_error}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      redirect_valid = v[i].rv;
      redirect_addr  = v[i].ra;
      imem_ack       = v[i].ack;
      imem_rdata     = v[i].rd;
      instr_ready    = v[i].rdy;
      #1;
      check_all($sformatf("row%0d", i), v[i].req, v[i].addr, v[i].vld, v[i].out, v[i].ipc, v[i].pco);
      @(negedge clock);
    end
    idle_inputs();

    // asynchronous reset in the middle of HOLD
    check("hold_before_reset", {31'd0, instr_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 check_all("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1 check_all("rel_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    check("rel_req", {31'd0, imem_req}, 32'd1);
    // asynchronous reset in the middle of an unacked REQ
    #2 reset = 1'b1;
    #1 check_all("rst_req", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    @(negedge clock);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        check("to_last_req", {31'd0, imem_req}, 32'd1);
        check("to_last_err", {31'd0, fetch_error}, 32'd0);
      end
      @(negedge clock);
    end
    check("to_err", {31'd0, fetch_error}, 32'd1);
    check("to_req", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h80;
    imem_ack       = 1'b1;
    instr_ready    = 1'b1;
    repeat (3) @(negedge clock);
    idle_inputs();
    check("to_sticky_err", {31'd0, fetch_error}, 32'd1);
    check("to_sticky_req", {31'd0, imem_req}, 32'd0);
    check("to_sticky_vld", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1;
    #1 check("to_reset_err", {31'd0, fetch_error}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Consumer side of the program counter. It owns the fetch PC, presents it to instruction memory over a req/ack handshake, and returns each fetched word with its PC to decode over a valid/ready handshake. It accepts branch/jump redirects from execute, with squash of any in-flight fetch. It replaces a free-running PC so that slow memories and decode back-pressure are tolerated.

Parameters:
RESET_ADDR, 32'h00000000, first fetch address after reset
TIMEOUT_CYCLES, 16, REQ cycles without ack before error (FETCH_TIMEOUT_EN only)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  one-cycle pulse: load redirect_addr as next fetch PC
redirect_addr  input  32  branch/jump target; bits [1:0] ignored (treated as 0)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr_valid  output  1  instr_out/instr_pc hold a valid instruction
instr_ready  input  1  decode accepts instruction this cycle
instr_out  output  32  fetched instruction
instr_pc  output  32  address of instr_out
pc_out  output  32  current fetch PC
fetch_error  output  1  sticky timeout flag (present only with FETCH_TIMEOUT_EN)

Behaviour:
- Reset (async, any state): state=IDLE, pc_out=RESET_ADDR, imem_req=0, imem_addr=RESET_ADDR, instr_valid=0, instr_out=0, instr_pc=0, pending redirect cleared, fetch_error=0.
- States: IDLE, REQ, HOLD (+ERROR with macro).
- IDLE: one cycle after reset release -> REQ. Outputs idle.
- REQ: imem_req=1, imem_addr=pc_out.
  - imem_ack=1, no redirect pending or arriving: capture instr_out=imem_rdata and instr_pc=pc_out; pc_out<=pc_out+4; -> HOLD.
  - imem_ack=0: stay. imem_addr must not change.
  - redirect_valid without ack: latch target into pending register, do not change imem_addr.
  - On ack with a redirect pending or arriving the same cycle: discard imem_rdata, pc_out<=target, clear pending, stay REQ; the new address is presented next cycle. If the pending register is already full, the newer redirect overwrites it.
- HOLD: instr_valid=1, instr_out/instr_pc stable, imem_req=0.
  - instr_ready=1: -> REQ with pc_out unchanged (already incremented), instr_valid=0 next cycle.
  - redirect_valid=1 (priority over instr_ready): instr_valid<=0 (instruction squashed even if ready=1 same cycle), pc_out<=redirect_addr&~3, -> REQ.
- Latency: redirect or handoff to imem_req=1 is 1 cycle. Single-cycle-ack memory with ready always high gives 1 instruction per 2 cycles.
- Arithmetic: pc_out+4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000 without error.
- Reset asserted mid-REQ or mid-HOLD: all outputs return to reset values immediately; no partial fetch survives.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: fetch_error port exists. A counter clears on entry to REQ and increments each REQ cycle with imem_ack=0. When the count reaches TIMEOUT_CYCLES, fetch_error<=1 (sticky) and the FSM goes to ERROR: imem_req=0, instr_valid=0, redirects ignored. Only reset exits ERROR. An ack on the same cycle the count reaches TIMEOUT_CYCLES wins, and no error is raised.
- Undefined: no port, no counter; REQ waits indefinitely.

Test Plan:
- Reset release, ack same cycle, ready=1, rdata=32'h20080005 -> imem_addr 0,4,8 on successive REQ cycles; instr_pc 0 then 4; instr_out=32'h20080005; pc_out=4 after first ack.
- ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr held at 32'h00000000; instr_valid asserted the cycle after ack.
- HOLD with instr_ready=0 for 5 cycles -> instr_valid, instr_out, instr_pc stable; no imem_req.
- redirect_valid with redirect_addr=32'h00400023 in HOLD, ready=1 same cycle -> instruction squashed; next imem_addr=32'h00400020.
- redirect during unacked REQ at addr 8, target 32'h00000100 -> addr 8 held until ack, data dropped (instr_valid stays 0), next imem_addr=32'h00000100.
- pc_out=32'hFFFFFFFC, ack -> pc_out=0. With FETCH_TIMEOUT_EN and ack withheld 16 cycles -> fetch_error=1, imem_req=0 until reset.
